// File: rtl/llc_bus_responder_if.sv
// Bus-operation interface between the LLC and the system-bus responder:
// request/response handshake, snoop broadcast, writeback strobe, memory
// port and the transaction counters.
interface llc_bus_responder_if #(
   parameter int ADDR_BITS = 32,
   parameter int N_AGENTS  = 3
);
   logic                   req_valid;
   logic                   req_ready;
   logic [1:0]             req_op;
   logic [ADDR_BITS-1:0]   req_addr;

   logic                   rsp_valid;
   logic [1:0]             rsp_result;
   logic                   rsp_timeout;
   logic                   rsp_error;

   logic [N_AGENTS-1:0]    snp_valid;
   logic [1:0]             snp_op;
   logic [ADDR_BITS-1:0]   snp_addr;
   logic [N_AGENTS-1:0]    snp_ack;
   logic [2*N_AGENTS-1:0]  snp_result;

   logic                   wb_done;

   logic                   mem_valid;
   logic                   mem_we;
   logic [ADDR_BITS-1:0]   mem_addr;
   logic                   mem_ready;

   logic [31:0]            cnt_txn;
   logic [31:0]            cnt_hitm;

   modport slave (
      input  req_valid, req_op, req_addr,
      input  snp_ack, snp_result, wb_done, mem_ready,
      output req_ready, rsp_valid, rsp_result, rsp_timeout, rsp_error,
      output snp_valid, snp_op, snp_addr,
      output mem_valid, mem_we, mem_addr,
      output cnt_txn, cnt_hitm
   );

   modport master (
      output req_valid, req_op, req_addr,
      output snp_ack, snp_result, wb_done, mem_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_timeout, rsp_error,
      input  snp_valid, snp_op, snp_addr,
      input  mem_valid, mem_we, mem_addr,
      input  cnt_txn, cnt_hitm
   );
endinterface

// File: rtl/llc_bus_responder.sv
// System-bus responder for LLC bus operations. Takes one operation at a
// time, snoops the peer caches, combines their results, sequences a peer
// writeback when one holds the line modified, then the memory access, and
// returns the combined snoop result.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for a new operation
// S_SNOOP   | snoop broadcast, collecting per-agent results until all ack
//           | or the ack timer expires
// S_WAIT_WB | a peer returned HITM; waiting for its writeback to finish
// S_MEM     | memory request outstanding until mem_ready
// S_RESP    | single-cycle response to the LLC
module llc_bus_responder #(
   parameter int ADDR_BITS        = 32,
   parameter int BYTE_OFFSET_BITS = 6,
   parameter int N_AGENTS         = 3,
   parameter int TIMEOUT          = 16
) (
   input  logic                clk,
   input  logic                rst,
   llc_bus_responder_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SNOOP,
      S_WAIT_WB,
      S_MEM,
      S_RESP
   } state_t;

   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_INV   = 2'd2;

   localparam logic [1:0] RES_HIT   = 2'd0;
   localparam logic [1:0] RES_HITM  = 2'd1;
   localparam logic [1:0] RES_NOHIT = 2'd2;

   localparam int TW = $clog2(TIMEOUT) + 1;

   state_t                 state_q, state_d;
   logic [1:0]             op_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [N_AGENTS-1:0]    pend_q, pend_d;
   logic [1:0]             res_q [N_AGENTS];
   logic [1:0]             res_d [N_AGENTS];
   logic [TW-1:0]          timer_q;
   logic [1:0]             result_q;
   logic                   timeout_q;
   logic                   error_q;
   logic [31:0]            cnt_txn_q;
   logic [31:0]            cnt_hitm_q;

   logic                   accept;
   logic                   tmo_hit;
   logic                   snoop_done;
   logic                   hitm_seen;
   logic                   hitm_multi;
   logic                   hit_seen;
   logic [1:0]             comb_result;
   logic [ADDR_BITS-1:0]   line_addr;

   assign line_addr = {bus.req_addr[ADDR_BITS-1:BYTE_OFFSET_BITS], {BYTE_OFFSET_BITS{1'b0}}};
   assign accept    = (state_q == S_IDLE) && bus.req_valid;

   // Fold this cycle's acks into the per-agent results; anything still
   // pending when the timer expires keeps its NOHIT default.
   always_comb begin
      pend_d     = pend_q;
      hitm_seen  = 1'b0;
      hitm_multi = 1'b0;
      hit_seen   = 1'b0;
      for (int i = 0; i < N_AGENTS; i++) begin
         res_d[i] = res_q[i];
         if (bus.snp_ack[i] && pend_q[i]) begin
            pend_d[i] = 1'b0;
            res_d[i]  = (bus.snp_result[2*i +: 2] == 2'd3) ? RES_NOHIT : bus.snp_result[2*i +: 2];
         end
         if (res_d[i] == RES_HITM) begin
            if (hitm_seen) hitm_multi = 1'b1;
            hitm_seen = 1'b1;
         end else if (res_d[i] == RES_HIT) begin
            hit_seen = 1'b1;
         end
      end
      comb_result = hitm_seen ? RES_HITM : (hit_seen ? RES_HIT : RES_NOHIT);
      tmo_hit     = (timer_q == TW'(TIMEOUT - 1)) && (pend_d != '0);
      snoop_done  = (state_q == S_SNOOP) && ((pend_d == '0) || tmo_hit);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = (bus.req_op == OP_WRITE) ? S_MEM : S_SNOOP;
         end
         S_SNOOP: begin
            if (snoop_done) begin
               if (op_q == OP_INV)               state_d = S_RESP;
               else if (comb_result == RES_HITM) state_d = S_WAIT_WB;
               else                              state_d = S_MEM;
            end
         end
         S_WAIT_WB: begin
            if (bus.wb_done) state_d = S_MEM;
         end
         S_MEM: begin
            if (bus.mem_ready) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode; everything is forced low while reset is held.
   always_comb begin
      bus.req_ready   = 1'b0;
      bus.rsp_valid   = 1'b0;
      bus.rsp_result  = 2'd0;
      bus.rsp_timeout = 1'b0;
      bus.rsp_error   = 1'b0;
      bus.snp_valid   = '0;
      bus.snp_op      = 2'd0;
      bus.snp_addr    = '0;
      bus.mem_valid   = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.cnt_txn     = '0;
      bus.cnt_hitm    = '0;
      if (!rst) begin
         bus.req_ready = (state_q == S_IDLE);
         bus.snp_op    = op_q;
         bus.snp_addr  = addr_q;
         bus.mem_addr  = addr_q;
         bus.cnt_txn   = cnt_txn_q;
         bus.cnt_hitm  = cnt_hitm_q;
         if (state_q == S_SNOOP) bus.snp_valid = pend_q;
         if (state_q == S_MEM) begin
            bus.mem_valid = 1'b1;
            bus.mem_we    = (op_q == OP_WRITE);
         end
         if (state_q == S_RESP) begin
            bus.rsp_valid   = 1'b1;
            bus.rsp_result  = result_q;
            bus.rsp_timeout = timeout_q;
            bus.rsp_error   = error_q;
         end
      end
   end

   // Transaction context, snoop bookkeeping and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= 2'd0;
         addr_q     <= '0;
         pend_q     <= '0;
         timer_q    <= '0;
         result_q   <= RES_NOHIT;
         timeout_q  <= 1'b0;
         error_q    <= 1'b0;
         cnt_txn_q  <= '0;
         cnt_hitm_q <= '0;
         for (int i = 0; i < N_AGENTS; i++) res_q[i] <= RES_NOHIT;
      end else begin
         if (accept) begin
            op_q      <= bus.req_op;
            addr_q    <= line_addr;
            cnt_txn_q <= cnt_txn_q + 32'd1;
            pend_q    <= (bus.req_op == OP_WRITE) ? '0 : '1;
            timer_q   <= '0;
            result_q  <= RES_NOHIT;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
            for (int i = 0; i < N_AGENTS; i++) res_q[i] <= RES_NOHIT;
         end
         if (state_q == S_SNOOP) begin
            pend_q  <= tmo_hit ? '0 : pend_d;
            timer_q <= timer_q + TW'(1);
            for (int i = 0; i < N_AGENTS; i++) res_q[i] <= res_d[i];
            if (snoop_done) begin
               result_q  <= comb_result;
               error_q   <= hitm_multi;
               timeout_q <= tmo_hit;
            end
         end
         if ((state_q == S_SNOOP) && (state_d == S_WAIT_WB)) cnt_hitm_q <= cnt_hitm_q + 32'd1;
      end
   end

endmodule

// File: doc/llc_bus_responder.md
Name: llc_bus_responder

Overview:
- System-bus end of the LLC bus-operation interface. Accepts one bus operation at a time from the LLC (READ, WRITE, INVALIDATE, RWIM).
- Broadcasts the snoop to N peer caches, collects their snoop results and combines them. Sequences any peer HITM writeback and the memory access.
- Returns the combined snoop result to the LLC. Replaces the address-bit snoop stub with a real cycle-accurate responder.

Parameters:
ADDR_BITS, 32, physical address width
BYTE_OFFSET_BITS, 6, line offset bits; these are zeroed on snoop/mem addresses
N_AGENTS, 3, number of peer snoopers
TIMEOUT, 16, max cycles waiting for snoop acks (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  LLC bus-op request
req_ready  out  1  responder can accept
req_op  in  2  0=READ 1=WRITE 2=INVALIDATE 3=RWIM
req_addr  in  ADDR_BITS  request address
rsp_valid  out  1  one-cycle response pulse
rsp_result  out  2  combined snoop result: 0=HIT 1=HITM 2=NOHIT
rsp_timeout  out  1  at least one agent timed out (valid with rsp_valid)
rsp_error  out  1  more than one agent returned HITM (valid with rsp_valid)
snp_valid  out  N_AGENTS  per-agent snoop request
snp_op  out  2  latched op
snp_addr  out  ADDR_BITS  line-aligned latched address
snp_ack  in  N_AGENTS  per-agent result strobe
snp_result  in  2*N_AGENTS  agent i result in bits [2i+1:2i]; 3 is treated as NOHIT
wb_done  in  1  HITM owner finished writeback
mem_valid  out  1  memory request
mem_we  out  1  1=write 0=read
mem_addr  out  ADDR_BITS  line-aligned address
mem_ready  in  1  memory accepts/completes
cnt_txn  out  32  accepted requests, wraps
cnt_hitm  out  32  transactions with combined HITM, wraps

Behaviour:
- Reset:
  - While rst is high, all outputs are 0, the state is IDLE, counters are 0 and the pending mask is clear.
  - req_ready is 0 while rst is high and 1 in the first cycle after deassertion.
  - rst mid-transaction aborts it; no rsp_valid is produced.
- FSM: IDLE, SNOOP, WAIT_WB, MEM, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at edge T: latch op and line-aligned addr, cnt_txn++.
  - WRITE goes to MEM. All other ops go to SNOOP, with pending mask set to all ones and the timer at 0.
- SNOOP:
  - snp_valid = pending mask. snp_op and snp_addr are held stable.
  - snp_ack[i] with pending[i] set: capture result, clear pending[i]. snp_ack for a non-pending agent is ignored.
  - Timer increments each cycle. When timer==TIMEOUT-1 and bits are still pending, those agents count as NOHIT and the timeout flag is set. An ack in that same cycle wins for that agent.
  - Leave the state when pending becomes empty.
  - Combine results: HITM if any HITM, else HIT if any HIT, else NOHIT. More than one HITM sets the error flag; the result is still HITM.
  - Exit transitions:
    - INVALIDATE goes to RESP.
    - READ or RWIM with HITM goes to WAIT_WB.
    - READ or RWIM otherwise goes to MEM.
- WAIT_WB: wait for wb_done, then go to MEM. There is no timeout. cnt_hitm increments on entry.
- MEM:
  - mem_valid=1; mem_we=1 only for WRITE.
  - Hold until mem_ready, then go to RESP.
  - mem_ready in the first MEM cycle is legal.
- RESP:
  - rsp_valid=1 for exactly one cycle with result, timeout and error flags; return to IDLE.
  - WRITE always returns NOHIT with both flags 0.
- Latency, with T the acceptance edge:
  - INVALIDATE with all acks at T+1: rsp_valid at T+2.
  - READ, no HITM, all acks at T+1, mem_ready at T+2: rsp_valid at T+3.
  - WRITE with mem_ready at T+1: rsp_valid at T+2.
- A req_valid arriving outside IDLE is not accepted; the LLC must hold it.
- All flags clear on each new acceptance.

Test Plan:
- READ addr 0x0000_1234; acks at T+1 with results {NOHIT,NOHIT,NOHIT}; mem_ready immediately -> mem_addr=0x0000_1200, mem_we=0, rsp_valid at T+3 with result=2, cnt_txn=1.
- RWIM 0xABCD_0040; agent1 returns HITM at T+2, others HIT at T+1; wb_done at T+6; mem_ready at T+7 -> rsp_result=1, cnt_hitm=1, rsp_error=0, mem read issued only after wb_done.
- INVALIDATE with agent2 never acking, TIMEOUT=16 -> snp_valid[2] high for 16 cycles, rsp_result=HIT if others HIT, rsp_timeout=1, no mem_valid.
- WRITE 0x0000_00FF -> no snp_valid; mem_we=1, mem_addr=0x0000_00C0, rsp_result=2.
- Two agents return HITM on READ -> rsp_result=1, rsp_error=1; a second req_valid held during the transaction is accepted only after the RESP cycle.
- rst asserted in WAIT_WB -> all outputs 0 next cycle, no rsp_valid; a fresh READ afterwards completes normally.
